// File: rtl/conv3x3_stream_if.sv
// Stream bundle for conv3x3_stream: raw Bayer samples in, convolved gray pixels out.
// The thresh member exists only when CONV_THRESH_EN is defined.
interface conv3x3_stream_if #(
    parameter int DATA_W = 12
);
    logic [10:0]       x_cont;
    logic [10:0]       y_cont;
    logic [DATA_W-1:0] data;
    logic              dval;
    logic [2:0]        mode;
`ifdef CONV_THRESH_EN
    logic [DATA_W-1:0] thresh;
`endif
    logic [DATA_W-1:0] pixel;
    logic              pix_vld;
    logic              border;

    modport master (
`ifdef CONV_THRESH_EN
        output thresh,
`endif
        output x_cont, y_cont, data, dval, mode,
        input  pixel, pix_vld, border
    );

    modport slave (
`ifdef CONV_THRESH_EN
        input  thresh,
`endif
        input  x_cont, y_cont, data, dval, mode,
        output pixel, pix_vld, border
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Bayer quad -> gray, then a per-frame selected 3x3 kernel (gray/Sobel-H/Sobel-V/|G|/Gaussian).
// Optional feature macro CONV_THRESH_EN binarises the kernel result against bus.thresh.
module conv3x3_stream #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640
) (
    input  logic             clk,
    input  logic             rst,
    conv3x3_stream_if.slave  bus
);
    localparam int RAW_D  = 2 * IMG_W;
    localparam int RAW_AW = $clog2(RAW_D);
    localparam int GAW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW     = DATA_W + 3;
    localparam int MW     = DATA_W + 4;
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    function automatic logic signed [SW-1:0] sext(input logic [DATA_W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    function automatic logic [MW-1:0] uext(input logic [DATA_W-1:0] v);
        return {4'b0000, v};
    endfunction

    function automatic logic [MW-1:0] abs_ext(input logic signed [SW-1:0] v);
        logic [SW-1:0] m;
        m = v[SW-1] ? $unsigned(-v) : $unsigned(v);
        return {1'b0, m};
    endfunction

    function automatic logic [DATA_W-1:0] sat_pix(input logic [MW-1:0] v);
        return (v > MW'(PIX_MAX)) ? PIX_MAX : v[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] raw_mem [RAW_D];
    logic [RAW_AW-1:0] raw_ptr;
    logic [DATA_W-1:0] above, above_prev, data_prev;
    logic [DATA_W+1:0] quad_sum;
    logic              quad_ok;

    logic [DATA_W-1:0] gray_p0;
    logic [9:0]        gc_p0, gr_p0;
    logic              vld_p0;
    logic [2:0]        mode_act;

    assign above    = raw_mem[raw_ptr];
    assign quad_ok  = bus.dval && bus.x_cont[0] && bus.y_cont[0];
    assign quad_sum = {2'b00, above_prev} + {2'b00, above} + {2'b00, data_prev} + {2'b00, bus.data};

    always_ff @(posedge clk) begin
        if (bus.dval) begin
            raw_mem[raw_ptr] <= bus.data;
        end
    end

    // stage p0: raw line delay and 2x2 quad averaging into gray
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_ptr    <= '0;
            above_prev <= '0;
            data_prev  <= '0;
            gray_p0    <= '0;
            gc_p0      <= '0;
            gr_p0      <= '0;
            vld_p0     <= 1'b0;
            mode_act   <= 3'd0;
        end else begin
            vld_p0 <= quad_ok;
            if (bus.dval) begin
                raw_ptr    <= (raw_ptr == RAW_AW'(RAW_D - 1)) ? '0 : raw_ptr + RAW_AW'(1);
                above_prev <= above;
                data_prev  <= bus.data;
            end
            if (quad_ok) begin
                gray_p0 <= DATA_W'(quad_sum >> 2);
                gc_p0   <= bus.x_cont[10:1];
                gr_p0   <= bus.y_cont[10:1];
                if (bus.x_cont[10:1] == 10'd0 && bus.y_cont[10:1] == 10'd0) begin
                    mode_act <= (bus.mode > 3'd4) ? 3'd0 : bus.mode;
                end
            end
        end
    end

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [GAW-1:0]    gptr, gaddr;
    logic [DATA_W-1:0] col  [3];
    logic [DATA_W-1:0] win  [3][3];
    logic [DATA_W-1:0] nwin [3][3];

    assign gaddr  = (gc_p0 == 10'd0) ? '0 : gptr;
    assign col[0] = lb2[gaddr];
    assign col[1] = lb1[gaddr];
    assign col[2] = gray_p0;

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            lb1[gaddr] <= gray_p0;
            lb2[gaddr] <= lb1[gaddr];
        end
    end

    // kernel works on the window as it will look after this pixel shifts in
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
            nwin[r][2] = col[r];
        end
    end

    logic signed [SW-1:0] gh, gv;
    logic [MW-1:0]        gsum, mag;
    logic [DATA_W-1:0]    kres, res;
    logic                 border_p0;

    always_comb begin
        gh = (sext(nwin[2][0]) + (sext(nwin[2][1]) <<< 1) + sext(nwin[2][2]))
           - (sext(nwin[0][0]) + (sext(nwin[0][1]) <<< 1) + sext(nwin[0][2]));
        gv = (sext(nwin[0][2]) + (sext(nwin[1][2]) <<< 1) + sext(nwin[2][2]))
           - (sext(nwin[0][0]) + (sext(nwin[1][0]) <<< 1) + sext(nwin[2][0]));
        gsum = uext(nwin[0][0]) + (uext(nwin[0][1]) << 1) + uext(nwin[0][2])
             + (uext(nwin[1][0]) << 1) + (uext(nwin[1][1]) << 2) + (uext(nwin[1][2]) << 1)
             + uext(nwin[2][0]) + (uext(nwin[2][1]) << 1) + uext(nwin[2][2]);
        mag  = abs_ext(gh) + abs_ext(gv);
        case (mode_act)
            3'd1:    kres = sat_pix(abs_ext(gh));
            3'd2:    kres = sat_pix(abs_ext(gv));
            3'd3:    kres = sat_pix(mag);
            3'd4:    kres = DATA_W'(gsum >> 4);
            default: kres = nwin[1][1];
        endcase
    end

`ifdef CONV_THRESH_EN
    assign res = (kres >= bus.thresh) ? PIX_MAX : '0;
`else
    assign res = kres;
`endif
    assign border_p0 = (gc_p0 < 10'd2) || (gr_p0 < 10'd2);

    logic [DATA_W-1:0] pix_p1;
    logic              vld_p1, bord_p1;

    // stage p1: window shift and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            gptr    <= '0;
            pix_p1  <= '0;
            vld_p1  <= 1'b0;
            bord_p1 <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            vld_p1  <= vld_p0;
            bord_p1 <= vld_p0 && border_p0;
            pix_p1  <= (vld_p0 && !border_p0) ? res : '0;
            if (vld_p0) begin
                gptr <= (gaddr == GAW'(IMG_W - 1)) ? '0 : gaddr + GAW'(1);
                win  <= nwin;
            end
        end
    end

    assign bus.pixel   = pix_p1;
    assign bus.pix_vld = vld_p1;
    assign bus.border  = bord_p1;
endmodule
